four_bit_divider: RTL and testbench
===================================

FOUR_BIT_DIVIDER -- requirements
Module: four_bit_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port A, input, 8 bits: unsigned dividend (product width of the 4x4 multiplier).
REQ-005 SHALL have port B, input, 4 bits: unsigned divisor.
REQ-006 SHALL have port Q, output, 8 bits: unsigned quotient, registered.
REQ-007 SHALL have port R, output, 4 bits: unsigned remainder, registered.
REQ-008 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse when Q/R/dbz become valid.
REQ-010 SHALL have port dbz, output, 1 bit: divide-by-zero flag for the last result.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 In IDLE, an edge with start=1 SHALL capture A and B into internal registers, clear the iteration counter, and enter RUN; busy SHALL be high from that edge.
REQ-013 A and B SHALL be ignored except at the capture edge; changes during RUN SHALL NOT affect the result.
REQ-014 RUN SHALL perform restoring division, one quotient bit per edge, MSB first: shift {partial remainder, dividend} left by one, subtract B from the 5-bit partial remainder, keep the difference and set the quotient bit to 1 if non-negative, else restore and set the bit to 0.
REQ-015 RUN SHALL last exactly 8 edges; on the 8th RUN edge Q, R and dbz SHALL be updated and the FSM SHALL enter DONE.
REQ-016 In DONE, done SHALL be 1 and busy 0 for exactly one cycle; the next edge SHALL return to IDLE.
REQ-017 Latency: capture edge = edge 0; done high in the cycle after edge 8; done is never high for two consecutive cycles.
REQ-018 If B=0 at capture, the FSM SHALL skip RUN and enter DONE on edge 1 with Q=8'hFF, R=A[3:0], dbz=1.
REQ-019 For B!=0, dbz SHALL be 0 and Q*B+R SHALL equal A with R<B.
REQ-020 start SHALL be ignored in RUN and DONE; an edge with start=1 in IDLE immediately after DONE SHALL begin a new operation.
REQ-021 Q, R and dbz SHALL hold their last value from the done pulse until the next done pulse; a new capture SHALL NOT clear them.
REQ-022 The iteration counter SHALL be 3 or 4 bits and SHALL NOT wrap during RUN.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force state IDLE, Q=0, R=0, busy=0, done=0, dbz=0, and clear the internal registers and counter.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after rst falls, the first start SHALL behave per REQ-012.
REQ-025 start SHALL be ignored while rst=1.

Verification
REQ-026 A=8'h32, B=4'h5, start pulse -> busy for 8 cycles, done in the cycle after edge 8, Q=8'h0A, R=0, dbz=0.
REQ-027 Back-to-back: A=8'h68, B=4'h8, then A=8'hC8, B=4'h7 with start the cycle after done -> Q=8'h0D, R=0; then Q=8'h1C, R=4'h4.
REQ-028 Boundaries: A=8'hFF, B=4'hF -> Q=8'h11, R=0; A=8'hFF, B=4'h1 -> Q=8'hFF, R=0; A=0, B=4'h3 -> Q=0, R=0.
REQ-029 A=8'h5A, B=0 -> done in the cycle after edge 1, busy never high, Q=8'hFF, R=4'hA, dbz=1; the next valid division clears dbz.
REQ-030 start held high and A/B changed during RUN -> result matches the captured operands; exactly one done pulse per accepted start.
REQ-031 rst pulsed between clock edges at RUN iteration 4 -> all outputs 0 at once, no done pulse; a subsequent A=8'h32, B=4'h5 gives Q=8'h0A.

Source files
------------

// File: rtl/four_bit_divider.sv
// Sequential restoring divider: 8-bit dividend by 4-bit divisor, one quotient
// bit per clock, with a divide-by-zero shortcut that reports in a single step.
module four_bit_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [3:0] B,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic [7:0]  dvd_r;
  logic [3:0]  div_r;
  logic [3:0]  rem_r;
  logic [3:0]  cnt_r;
  logic        zdiv_r;

  logic [4:0]  shifted_s;
  logic [5:0]  diff_s;
  logic        qbit_s;
  logic [3:0]  rem_s;
  logic [7:0]  dvd_s;
  logic        capture_s;
  logic        finish_s;

  // Next-state and control decode.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          capture_s = 1'b1;
          state_s   = RUN;
        end else begin
          state_s   = IDLE;
        end
      end
      RUN: begin
        if (zdiv_r || (cnt_r == 4'd7)) begin
          finish_s = 1'b1;
          state_s  = DONE;
        end else begin
          state_s  = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  always_comb begin
    shifted_s = {rem_r, dvd_r[7]};
    diff_s    = {1'b0, shifted_s} - {2'b00, div_r};
    if (diff_s[5]) begin
      qbit_s = 1'b0;
      rem_s  = shifted_s[3:0];
    end else begin
      qbit_s = 1'b1;
      rem_s  = diff_s[3:0];
    end
    dvd_s = {dvd_r[6:0], qbit_s};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working registers: captured operands, partial remainder and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r  <= 8'd0;
      div_r  <= 4'd0;
      rem_r  <= 4'd0;
      cnt_r  <= 4'd0;
      zdiv_r <= 1'b0;
    end else if (capture_s) begin
      dvd_r  <= A;
      div_r  <= B;
      rem_r  <= 4'd0;
      cnt_r  <= 4'd0;
      zdiv_r <= (B == 4'd0);
    end else if ((state_r == RUN) && !finish_s) begin
      dvd_r  <= dvd_s;
      rem_r  <= rem_s;
      cnt_r  <= cnt_r + 4'd1;
    end else begin
      dvd_r  <= dvd_r;
      rem_r  <= rem_r;
      cnt_r  <= cnt_r;
    end
  end

  // Registered status and results; results persist until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q    <= 8'd0;
      R    <= 4'd0;
      dbz  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= finish_s;
      if (capture_s) begin
        busy <= (B != 4'd0);
      end else if (finish_s) begin
        busy <= 1'b0;
      end else begin
        busy <= busy;
      end
      if (finish_s && zdiv_r) begin
        Q   <= 8'hFF;
        R   <= dvd_r[3:0];
        dbz <= 1'b1;
      end else if (finish_s) begin
        Q   <= dvd_s;
        R   <= rem_s;
        dbz <= 1'b0;
      end else begin
        Q   <= Q;
        R   <= R;
        dbz <= dbz;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_divider.sv
// Directed bench for four_bit_divider with hand-computed quotients/remainders.
module tb_four_bit_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [3:0] B;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       dbz;

  int n_vec;
  int n_bad;
  logic [7:0] prev_q;
  logic [3:0] prev_r;

  four_bit_divider dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Run one division; scramble or hold inputs after capture to prove they are ignored.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic edbz, input logic hold);
    int edges;
    int busy_cnt;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_at_capture", {31'd0, busy}, {31'd0, (b != 4'd0)});
    chk("q_held_at_capture", {24'd0, Q}, {24'd0, prev_q});
    chk("r_held_at_capture", {28'd0, R}, {28'd0, prev_r});
    if (!hold) start = 1'b0;
    A = ~a; B = ~b;
    edges = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
    chk("latency", edges, (b == 4'd0) ? 32'd1 : 32'd8);
    chk("busy_cycles", busy_cnt, (b == 4'd0) ? 32'd0 : 32'd8);
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    chk("Q", {24'd0, Q}, {24'd0, eq});
    chk("R", {28'd0, R}, {28'd0, er});
    chk("dbz", {31'd0, dbz}, {31'd0, edbz});
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    int extra_done;
    n_vec = 0; n_bad = 0;
    prev_q = 8'd0; prev_r = 4'd0;
    start = 1'b0; A = 8'd0; B = 4'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_Q", {24'd0, Q}, 32'd0);
    chk("reset_R", {28'd0, R}, 32'd0);
    chk("reset_flags", {29'd0, busy, done, dbz}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_div(8'h32, 4'h5, 8'h0A, 4'h0, 1'b0, 1'b0);
    do_div(8'h68, 4'h8, 8'h0D, 4'h0, 1'b0, 1'b0);
    do_div(8'hC8, 4'h7, 8'h1C, 4'h4, 1'b0, 1'b0);
    do_div(8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 1'b0);
    do_div(8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 1'b0);
    do_div(8'h00, 4'h3, 8'h00, 4'h0, 1'b0, 1'b0);
    do_div(8'h5A, 4'h0, 8'hFF, 4'hA, 1'b1, 1'b0);
    do_div(8'h64, 4'h9, 8'h0B, 4'h1, 1'b0, 1'b0);
    do_div(8'hB7, 4'hD, 8'h0E, 4'h1, 1'b0, 1'b1);

    // Abort mid-RUN with an asynchronous reset pulse.
    @(negedge clk);
    A = 8'hC8; B = 4'h7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_Q", {24'd0, Q}, 32'd0);
    chk("abort_R", {28'd0, R}, 32'd0);
    chk("abort_flags", {29'd0, busy, done, dbz}, 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_ignored_in_reset", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    extra_done = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    chk("no_done_after_abort", extra_done, 32'd0);
    prev_q = 8'd0; prev_r = 4'd0;
    do_div(8'h32, 4'h5, 8'h0A, 4'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
